regfile_scoreboard: RTL

//  Write-back sink of the pipeline: consumes WB-stage write port (wb_regwrite/wb_rd/wb_write_data) into a

---
 rtl/regfile_scoreboard_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 77 +++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back port bundle for the register file with pending-write scoreboard.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            wb_regwrite;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_write_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_used;
  logic            rs2_used;
  logic            issue_valid;
  logic            issue_regwrite;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic [31:0]     write_count;
  logic [XLEN-1:0] last_wb_data;

  modport master (
    output wb_regwrite, wb_rd, wb_write_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           issue_valid, issue_regwrite, issue_rd, flush,
    input  rs1_data, rs2_data, stall, write_count, last_wb_data
  );

  modport slave (
    input  wb_regwrite, wb_rd, wb_write_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
           issue_valid, issue_regwrite, issue_rd, flush,
    output rs1_data, rs2_data, stall, write_count, last_wb_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Write-back register file with WB->decode bypass and per-register pending-write
// counters that hold decode until outstanding writes to its sources have landed.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [XLEN-1:0]   regs     [NREGS];
  logic [PEND_W-1:0] pend     [NREGS];
  logic [PEND_W-1:0] pend_eff [NREGS];
  logic [NREGS-1:0]  inc, dec;
  logic              wb_commit, accept;
  logic              busy1, busy2, full_rd;

  assign wb_commit = bus.wb_regwrite && (bus.wb_rd != '0);

  // Per-register scoreboard: count still outstanding after this cycle's WB retires.
  for (genvar i = 0; i < NREGS; i++) begin : g_sb
    assign dec[i]      = wb_commit && (bus.wb_rd == AW'(i)) && (pend[i] != '0);
    assign inc[i]      = accept && (bus.issue_rd == AW'(i));
    assign pend_eff[i] = pend[i] - PEND_W'(dec[i]);

    // Flush wins over any same-cycle issue or retire; dec never underflows.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          pend[i] <= '0;
      else if (bus.flush) pend[i] <= '0;
      else                pend[i] <= pend[i] + PEND_W'(inc[i]) - PEND_W'(dec[i]);
    end
  end

  // A source is busy only if a write stays pending after this cycle's WB (which bypasses).
  always_comb begin
    busy1   = (bus.rs1_addr != '0) && (pend_eff[bus.rs1_addr] != '0);
    busy2   = (bus.rs2_addr != '0) && (pend_eff[bus.rs2_addr] != '0);
    full_rd = bus.issue_regwrite && (bus.issue_rd != '0) && (pend_eff[bus.issue_rd] == PMAX);
    bus.stall = bus.issue_valid && ((bus.rs1_used && busy1) || (bus.rs2_used && busy2) || full_rd);
  end

  assign accept = bus.issue_valid && !bus.stall && bus.issue_regwrite && (bus.issue_rd != '0);

  // Read ports: x0 hardwired, same-cycle WB forwarded ahead of the array.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0)                          bus.rs1_data = '0;
    else if (wb_commit && bus.wb_rd == bus.rs1_addr) bus.rs1_data = bus.wb_write_data;
    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0)                          bus.rs2_data = '0;
    else if (wb_commit && bus.wb_rd == bus.rs2_addr) bus.rs2_data = bus.wb_write_data;
  end

  // Register array write; x0 is never committed so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[bus.wb_rd] <= bus.wb_write_data;
    end
  end

  // Debug: committed-write count (free-running wrap) and last committed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.write_count  <= '0;
      bus.last_wb_data <= '0;
    end else if (wb_commit) begin
      bus.write_count  <= bus.write_count + 32'd1;
      bus.last_wb_data <= bus.wb_write_data;
    end
  end
endmodule
